seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised N-digit multiplexed 7-segment scan controller, the successor to the fixed 4-digit driver. It adds full hex decode, per-digit decimal points, leading-zero blanking, per-digit blink, and PWM brightness. A frame-synchronous input snapshot prevents tearing. It sits between the game/score logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits and anodes (2..8)
DIV_BITS, 18, digit slot length = 2^DIV_BITS clk cycles (2.62 ms at 100 MHz)
BRIGHT_BITS, 3, brightness resolution; must be <= DIV_BITS
BLINK_BITS, 6, frame counter width; blink phase = MSB (toggles every 2^(BLINK_BITS-1) frames)

Ports:
clk  in  1  system clock (100 MHz)
clr  in  1  reset, synchronous, active-high
en  in  1  display enable; 0 = all digits dark, scanning continues
x  in  4*NUM_DIGITS  hex values, digit i = x[4i+3:4i], digit 0 rightmost
dp_mask  in  NUM_DIGITS  1 = light dp of digit i
blink_mask  in  NUM_DIGITS  1 = digit i blinks
lzb  in  1  leading-zero blanking enable
bright  in  BRIGHT_BITS  brightness level, 0 = dimmest, all-ones = full on
a_to_g  out  7  segments {g,f,e,d,c,b,a}, active low, registered
an  out  NUM_DIGITS  anodes, active low, one-hot-low or all-ones, registered
dp  out  1  decimal point, active low, registered
frame_start  out  1  one-cycle pulse, registered, on the edge idx wraps to 0

Behaviour:
- Reset (clr=1 at posedge): prescaler=0, idx=0, frame_cnt=0, all snapshot regs=0. Outputs: a_to_g=7'h7F, an=all ones, dp=1, frame_start=0.
- Prescaler: DIV_BITS-bit free-running counter. At all-ones, idx advances on the same edge. idx wraps NUM_DIGITS-1 -> 0.
- On the wrap edge:
  - frame_cnt increments, wrapping modulo 2^BLINK_BITS.
  - x, dp_mask, blink_mask and lzb load into snapshot regs.
  - frame_start=1 for exactly that following cycle.
- Outputs are registered from the current (idx, prescaler, snapshot, en, bright, frame_cnt). This gives 1-cycle latency: the first cycle of each new slot still shows the previous digit.
- Decode of snapshot nibble, gfedcba active low:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
  - A=08 b=03 C=46 d=21 E=06 F=0E
- Digit i is blanked if any of the following holds:
  - en=0;
  - snapshot blink_mask[i]=1 and frame_cnt[BLINK_BITS-1]=1;
  - snapshot lzb=1, i>0, and snapshot nibbles i..NUM_DIGITS-1 are all 0 (digit 0 is never LZ-blanked);
  - PWM off: pwm_phase > bright, where pwm_phase = prescaler[DIV_BITS-1 : DIV_BITS-BRIGHT_BITS].
- Blanked digit outputs: an=all ones, a_to_g=7F, dp=1.
- Unblanked digit outputs: an[idx]=0 and all other anodes 1; a_to_g=decode; dp = ~dp_mask_snap[idx].
- bright and en are sampled live, not snapshotted.
- With bright=all ones, the duty cycle is 100%. With bright=k, the anode is on for (k+1)/2^BRIGHT_BITS of each slot, from the start of the slot.
- Reset mid-frame: the next cycle has reset values. Scanning restarts at digit 0, which shows value 0 until the first wrap loads the snapshot.
- Changes to x mid-frame are invisible until the next wrap.

Test Plan:
1. Bench params: NUM_DIGITS=4, DIV_BITS=4, BRIGHT_BITS=2, BLINK_BITS=2, bright=3, en=1. Hold clr 3 cycles, then x=16'h12AF. After the first wrap, the slot sequence (each 16 cycles, 1-cycle lag) must be:
   - an=1110 a_to_g=0E
   - an=1101 a_to_g=08
   - an=1011 a_to_g=24
   - an=0111 a_to_g=79
   - frame_start pulses once per 64 cycles.
2. lzb=1, x=16'h0005 -> only an=1110 with a_to_g=12 is ever lit. With x=16'h0000, only digit 0 is lit with a_to_g=40. With x=16'h0105, digit 3 is dark and digits 2..0 show 1,0,5.
3. dp_mask=4'b0100 -> dp=0 only while an=1011, dp=1 in all other slots and cycles.
4. bright=1 -> within each 16-cycle slot, the anode is low for exactly 8 cycles (prescaler 0..7, plus 1-cycle lag), then all ones. With bright=0, low for 4 cycles.
5. blink_mask=4'b0001 -> digit 0 is lit in frames with frame_cnt=0,1 and dark in frames with frame_cnt=2,3; other digits are unaffected. With en=0, an stays all ones while frame_start still pulses.
6. Change x from 16'h1111 to 16'h2222 mid-frame -> the remaining slots of that frame show 1 (a_to_g=79), and all digits show 2 after the next wrap. Asserting clr mid-slot -> the next cycle has an=1111, a_to_g=7F, dp=1, frame_start=0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller: hex decode, decimal points, leading-zero
// blanking, per-digit blink and PWM brightness, with inputs snapshotted once per frame.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DIV_BITS    = 18,
    parameter int unsigned BRIGHT_BITS = 3,
    parameter int unsigned BLINK_BITS  = 6
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] x,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lzb,
    input  logic [BRIGHT_BITS-1:0]  bright,
    output logic [6:0]              a_to_g,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    logic [DIV_BITS-1:0]     presc_q;
    logic [IdxW-1:0]         idx_q;
    logic [BLINK_BITS-1:0]   frame_cnt_q;
    logic [4*NUM_DIGITS-1:0] x_snap_q;
    logic [NUM_DIGITS-1:0]   dp_snap_q;
    logic [NUM_DIGITS-1:0]   blink_snap_q;
    logic                    lzb_snap_q;

    logic                    slot_end;
    logic                    wrap;
    logic [3:0]              nib;
    logic                    dp_sel;
    logic                    blink_sel;
    logic                    lz_sel;
    logic [BRIGHT_BITS-1:0]  pwm_phase;
    logic                    blank;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic                    dp_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        seg = 7'h7F;
        case (v)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign slot_end  = &presc_q;
    assign wrap      = slot_end && (idx_q == LastIdx);
    assign pwm_phase = presc_q[DIV_BITS-1 -: BRIGHT_BITS];

    // Select the current digit's snapshot fields; a digit is LZ-blanked only if it and
    // every more-significant nibble is zero, and never for digit 0.
    always_comb begin
        nib       = 4'h0;
        dp_sel    = 1'b0;
        blink_sel = 1'b0;
        lz_sel    = (idx_q != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                nib       = x_snap_q[4*i +: 4];
                dp_sel    = dp_snap_q[i];
                blink_sel = blink_snap_q[i];
            end
            if ((IdxW'(i) >= idx_q) && (x_snap_q[4*i +: 4] != 4'h0)) begin
                lz_sel = 1'b0;
            end
        end
    end

    always_comb begin
        blank = !en
             || (blink_sel && frame_cnt_q[BLINK_BITS-1])
             || (lzb_snap_q && lz_sel)
             || (pwm_phase > bright);
        seg_d = blank ? 7'h7F : hex_to_seg(nib);
        dp_d  = blank ? 1'b1 : ~dp_sel;
        an_d  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!blank && (idx_q == IdxW'(i))) begin
                an_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            x_snap_q     <= '0;
            dp_snap_q    <= '0;
            blink_snap_q <= '0;
            lzb_snap_q   <= 1'b0;
            a_to_g       <= 7'h7F;
            an           <= '1;
            dp           <= 1'b1;
            frame_start  <= 1'b0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (slot_end) begin
                idx_q <= wrap ? '0 : idx_q + 1'b1;
            end
            if (wrap) begin
                frame_cnt_q  <= frame_cnt_q + 1'b1;
                x_snap_q     <= x;
                dp_snap_q    <= dp_mask;
                blink_snap_q <= blink_mask;
                lzb_snap_q   <= lzb;
            end
            frame_start <= wrap;
            a_to_g      <= seg_d;
            an          <= an_d;
            dp          <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 16-cycle slots and 64-cycle frames.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        clr;
    logic        en;
    logic [15:0] x;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        lzb;
    logic [1:0]  bright;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    // Index of the last clock edge since reset release; outputs sampled after edge k
    // reflect prescaler = k%16 and digit (k/16)%4.
    int k = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .DIV_BITS   (4),
        .BRIGHT_BITS(2),
        .BLINK_BITS (2)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .en         (en),
        .x          (x),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lzb        (lzb),
        .bright     (bright),
        .a_to_g     (a_to_g),
        .an         (an),
        .dp         (dp),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        repeat (3) step();
        clr = 1'b0;
        k = -1;
    endtask

    task automatic test_reset();
        x = 16'h12AF; dp_mask = 4'h0; blink_mask = 4'h0; lzb = 1'b0; bright = 2'd3; en = 1'b1;
        clr = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (an !== 4'hF || a_to_g !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: an=%b a_to_g=%h dp=%b fs=%b, want an=1111 a_to_g=7f dp=1 fs=0",
                     an, a_to_g, dp, frame_start);
        end
        clr = 1'b0;
        k = -1;
    endtask

    task automatic test_decode();
        logic [3:0][6:0] seg_tbl;
        logic [3:0] an_want;
        logic [6:0] seg_want;
        int s, pulses;
        seg_tbl = {7'h79, 7'h24, 7'h08, 7'h0E};
        x = 16'h12AF; dp_mask = 4'h0; blink_mask = 4'h0; lzb = 1'b0; bright = 2'd3; en = 1'b1;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 192; c++) begin
            step();
            s = (k / 16) % 4;
            an_want = ~(4'b0001 << s);
            seg_want = (k < 64) ? 7'h40 : seg_tbl[s];
            n_cmp++;
            if (an !== an_want || a_to_g !== seg_want || dp !== 1'b1) begin
                n_bad++;
                $display("FAIL decode k=%0d: an=%b a_to_g=%h dp=%b, want an=%b a_to_g=%h dp=1",
                         k, an, a_to_g, dp, an_want, seg_want);
            end
            n_cmp++;
            if (frame_start !== ((k % 64) == 63)) begin
                n_bad++;
                $display("FAIL frame_start k=%0d: got %b want %b", k, frame_start, (k % 64) == 63);
            end
            if (frame_start === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 3) begin
            n_bad++;
            $display("FAIL frame_start_count: got %0d want 3", pulses);
        end
    endtask

    task automatic test_lzb();
        logic [3:0][6:0] exp_f [4];
        logic [3:0] an_want;
        logic [6:0] seg_want;
        int s, f;
        // 7f marks a dark slot
        exp_f[0] = {7'h40, 7'h40, 7'h40, 7'h40};
        exp_f[1] = {7'h7F, 7'h7F, 7'h7F, 7'h12};
        exp_f[2] = {7'h7F, 7'h7F, 7'h7F, 7'h40};
        exp_f[3] = {7'h7F, 7'h79, 7'h40, 7'h12};
        x = 16'h0005; dp_mask = 4'h0; blink_mask = 4'h0; lzb = 1'b1; bright = 2'd3; en = 1'b1;
        do_reset();
        for (int c = 0; c < 256; c++) begin
            step();
            f = k / 64;
            s = (k / 16) % 4;
            seg_want = exp_f[f][s];
            an_want = (seg_want == 7'h7F) ? 4'hF : ~(4'b0001 << s);
            n_cmp++;
            if (an !== an_want || a_to_g !== seg_want || dp !== 1'b1) begin
                n_bad++;
                $display("FAIL lzb k=%0d: an=%b a_to_g=%h dp=%b, want an=%b a_to_g=%h dp=1",
                         k, an, a_to_g, dp, an_want, seg_want);
            end
            if (k == 64) x = 16'h0000;
            if (k == 128) x = 16'h0105;
        end
    endtask

    task automatic test_dp();
        logic dp_want;
        int s;
        x = 16'h12AF; dp_mask = 4'b0100; blink_mask = 4'h0; lzb = 1'b0; bright = 2'd3; en = 1'b1;
        do_reset();
        for (int c = 0; c < 128; c++) begin
            step();
            s = (k / 16) % 4;
            dp_want = !(k >= 64 && s == 2);
            n_cmp++;
            if (dp !== dp_want) begin
                n_bad++;
                $display("FAIL dp k=%0d: an=%b dp=%b want dp=%b", k, an, dp, dp_want);
            end
        end
    endtask

    task automatic test_pwm();
        logic [3:0][6:0] seg_tbl;
        logic [3:0] an_want;
        logic [6:0] seg_want;
        int s, lim, low_cnt;
        seg_tbl = {7'h79, 7'h24, 7'h08, 7'h0E};
        x = 16'h12AF; dp_mask = 4'h0; blink_mask = 4'h0; lzb = 1'b0; bright = 2'd1; en = 1'b1;
        do_reset();
        low_cnt = 0;
        for (int c = 0; c < 192; c++) begin
            step();
            s = (k / 16) % 4;
            lim = (k < 128) ? 8 : 4;
            if ((k % 16) < lim) begin
                an_want = ~(4'b0001 << s);
                seg_want = (k < 64) ? 7'h40 : seg_tbl[s];
            end else begin
                an_want = 4'hF;
                seg_want = 7'h7F;
            end
            n_cmp++;
            if (an !== an_want || a_to_g !== seg_want) begin
                n_bad++;
                $display("FAIL pwm k=%0d: an=%b a_to_g=%h, want an=%b a_to_g=%h",
                         k, an, a_to_g, an_want, seg_want);
            end
            if (an !== 4'hF) low_cnt++;
            if ((k % 16) == 15) begin
                n_cmp++;
                if (low_cnt !== lim) begin
                    n_bad++;
                    $display("FAIL pwm_duty k=%0d: lit cycles %0d want %0d", k, low_cnt, lim);
                end
                low_cnt = 0;
            end
            if (k == 127) bright = 2'd0;
        end
    endtask

    task automatic test_blink();
        logic [3:0][6:0] seg_tbl;
        logic [3:0] an_want;
        logic [6:0] seg_want;
        int s, f, pulses;
        seg_tbl = {7'h79, 7'h24, 7'h08, 7'h0E};
        x = 16'h12AF; dp_mask = 4'h0; blink_mask = 4'b0001; lzb = 1'b0; bright = 2'd3; en = 1'b1;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 384; c++) begin
            step();
            f = k / 64;
            s = (k / 16) % 4;
            if (f == 5 || (s == 0 && (f == 2 || f == 3))) begin
                an_want = 4'hF;
                seg_want = 7'h7F;
            end else begin
                an_want = ~(4'b0001 << s);
                seg_want = (f == 0) ? 7'h40 : seg_tbl[s];
            end
            n_cmp++;
            if (an !== an_want || a_to_g !== seg_want || dp !== 1'b1) begin
                n_bad++;
                $display("FAIL blink_en k=%0d: an=%b a_to_g=%h dp=%b, want an=%b a_to_g=%h dp=1",
                         k, an, a_to_g, dp, an_want, seg_want);
            end
            if (f == 5 && frame_start === 1'b1) pulses++;
            if (k == 319) en = 1'b0;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL frame_start_en0: pulses %0d want 1", pulses);
        end
    endtask

    task automatic test_snapshot_clr();
        logic [6:0] seg_want;
        int s;
        x = 16'h1111; dp_mask = 4'h0; blink_mask = 4'h0; lzb = 1'b0; bright = 2'd3; en = 1'b1;
        do_reset();
        while (k < 170) begin
            step();
            s = (k / 16) % 4;
            seg_want = (k < 64) ? 7'h40 : (k < 128) ? 7'h79 : 7'h24;
            n_cmp++;
            if (an !== ~(4'b0001 << s) || a_to_g !== seg_want) begin
                n_bad++;
                $display("FAIL snapshot k=%0d: an=%b a_to_g=%h, want an=%b a_to_g=%h",
                         k, an, a_to_g, ~(4'b0001 << s), seg_want);
            end
            if (k == 90) x = 16'h2222;
        end
        clr = 1'b1;
        step();
        n_cmp++;
        if (an !== 4'hF || a_to_g !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_mid_slot: an=%b a_to_g=%h dp=%b fs=%b, want 1111 7f 1 0",
                     an, a_to_g, dp, frame_start);
        end
        step();
        clr = 1'b0;
        k = -1;
        step();
        n_cmp++;
        if (an !== 4'b1110 || a_to_g !== 7'h40 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_restart: an=%b a_to_g=%h fs=%b, want an=1110 a_to_g=40 fs=0",
                     an, a_to_g, frame_start);
        end
        while (k < 62) step();
        clr = 1'b1;
        step();
        n_cmp++;
        if (frame_start !== 1'b0 || an !== 4'hF || a_to_g !== 7'h7F) begin
            n_bad++;
            $display("FAIL clr_on_wrap: an=%b a_to_g=%h fs=%b, want an=1111 a_to_g=7f fs=0",
                     an, a_to_g, frame_start);
        end
        clr = 1'b0;
        k = -1;
    endtask

    initial begin
        clr = 1'b1; en = 1'b1; x = '0; dp_mask = '0; blink_mask = '0; lzb = 1'b0; bright = 2'd3;
        test_reset();
        test_decode();
        test_lzb();
        test_dp();
        test_pwm();
        test_blink();
        test_snapshot_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
